// File: rtl/sc_multi_timer.sv
// sc_multi_timer: multi-channel programmable period timer, periodic or one-shot per channel.
// Defining SC_MTIMER_PRESCALER_EN adds a shared PRESCALE_DIV prescaler that gates channel advance.

module sc_multi_timer #(
    parameter int COUNTER_DATAWIDTH = 8,
    parameter int CHANNELS          = 4,
    parameter int CHANNEL_SELWIDTH  = 2,
    parameter int PRESCALE_DIV      = 4
) (
    input  logic                         SC_MTIMER_CLOCK_50,
    input  logic                         SC_MTIMER_RESET_InHigh,
    input  logic                         SC_MTIMER_LOAD_InLow,
    input  logic                         SC_MTIMER_CLEAR_InLow,
    input  logic [CHANNEL_SELWIDTH-1:0]  SC_MTIMER_sel_InBUS,
    input  logic [COUNTER_DATAWIDTH-1:0] SC_MTIMER_data_InBUS,
    input  logic                         SC_MTIMER_mode_In,
    output logic [CHANNELS-1:0]          SC_MTIMER_tick_OutLow,
    output logic [CHANNELS-1:0]          SC_MTIMER_busy_OutBUS
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    if (CHANNELS < 1 || CHANNELS > (1 << CHANNEL_SELWIDTH) || PRESCALE_DIV < 1) begin : g_param_check
        $error("sc_multi_timer: invalid CHANNELS/CHANNEL_SELWIDTH/PRESCALE_DIV");
    end

    state_t                       state_q [CHANNELS];
    state_t                       state_d [CHANNELS];
    logic [COUNTER_DATAWIDTH-1:0] limit_q [CHANNELS];
    logic [COUNTER_DATAWIDTH-1:0] limit_d [CHANNELS];
    logic [COUNTER_DATAWIDTH-1:0] count_q [CHANNELS];
    logic [COUNTER_DATAWIDTH-1:0] count_d [CHANNELS];
    logic [CHANNELS-1:0]          mode_q;
    logic [CHANNELS-1:0]          mode_d;
    logic [CHANNELS-1:0]          tick_q;
    logic [CHANNELS-1:0]          tick_d;
    logic                         advance;

`ifdef SC_MTIMER_PRESCALER_EN
    localparam int DIV_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Free-running divider; the strobe fires on the cycle it wraps.
    always_comb begin
        advance = (div_q == DIV_W'(PRESCALE_DIV - 1));
        div_d   = advance ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge SC_MTIMER_CLOCK_50) begin
        if (SC_MTIMER_RESET_InHigh) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign advance = 1'b1;
`endif

    // Per-channel next state; load beats clear, and both beat the running count.
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        count_d = count_q;
        mode_d  = mode_q;
        tick_d  = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!SC_MTIMER_LOAD_InLow && (SC_MTIMER_sel_InBUS == CHANNEL_SELWIDTH'(i))) begin
                limit_d[i] = SC_MTIMER_data_InBUS;
                count_d[i] = '0;
                mode_d[i]  = SC_MTIMER_mode_In;
                state_d[i] = (SC_MTIMER_data_InBUS != '0) ? ST_RUN : ST_IDLE;
            end else if (!SC_MTIMER_CLEAR_InLow && (SC_MTIMER_sel_InBUS == CHANNEL_SELWIDTH'(i))) begin
                count_d[i] = '0;
                state_d[i] = ST_IDLE;
            end else if (state_q[i] == ST_RUN && advance) begin
                if (count_q[i] == limit_q[i]) begin
                    tick_d[i]  = 1'b0;
                    count_d[i] = '0;
                    if (mode_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end else begin
                    count_d[i] = count_q[i] + COUNTER_DATAWIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge SC_MTIMER_CLOCK_50) begin
        if (SC_MTIMER_RESET_InHigh) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                limit_q[i] <= '0;
                count_q[i] <= '0;
            end
            mode_q <= '0;
            tick_q <= '1;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        SC_MTIMER_busy_OutBUS = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            SC_MTIMER_busy_OutBUS[i] = (state_q[i] == ST_RUN);
        end
    end

    assign SC_MTIMER_tick_OutLow = tick_q;

endmodule

// File: tb/tb_sc_multi_timer.sv
// Directed bench for sc_multi_timer: a 4-channel instance plus a 3-channel instance
// sharing the same stimulus, used for the out-of-range select case.

module tb_sc_multi_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_n;
    logic       clear_n;
    logic [1:0] sel;
    logic [7:0] data;
    logic       mode;
    logic [3:0] tick;
    logic [3:0] busy;
    logic [2:0] tick3;
    logic [2:0] busy3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sc_multi_timer #(
        .COUNTER_DATAWIDTH(8),
        .CHANNELS(4),
        .CHANNEL_SELWIDTH(2),
        .PRESCALE_DIV(4)
    ) dut (
        .SC_MTIMER_CLOCK_50(clk),
        .SC_MTIMER_RESET_InHigh(rst),
        .SC_MTIMER_LOAD_InLow(load_n),
        .SC_MTIMER_CLEAR_InLow(clear_n),
        .SC_MTIMER_sel_InBUS(sel),
        .SC_MTIMER_data_InBUS(data),
        .SC_MTIMER_mode_In(mode),
        .SC_MTIMER_tick_OutLow(tick),
        .SC_MTIMER_busy_OutBUS(busy)
    );

    sc_multi_timer #(
        .COUNTER_DATAWIDTH(8),
        .CHANNELS(3),
        .CHANNEL_SELWIDTH(2),
        .PRESCALE_DIV(4)
    ) dut3 (
        .SC_MTIMER_CLOCK_50(clk),
        .SC_MTIMER_RESET_InHigh(rst),
        .SC_MTIMER_LOAD_InLow(load_n),
        .SC_MTIMER_CLEAR_InLow(clear_n),
        .SC_MTIMER_sel_InBUS(sel),
        .SC_MTIMER_data_InBUS(data),
        .SC_MTIMER_mode_In(mode),
        .SC_MTIMER_tick_OutLow(tick3),
        .SC_MTIMER_busy_OutBUS(busy3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        load_n  = 1'b1;
        clear_n = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic load(input logic [1:0] s, input logic [7:0] d, input logic m);
        load_n = 1'b0;
        sel    = s;
        data   = d;
        mode   = m;
        step;
        load_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (tick !== 4'b1111) begin
            failures++;
            $display("FAIL reset_tick got=%b exp=%b", tick, 4'b1111);
        end
        checks++;
        if (busy !== 4'b0000) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=%b", busy, 4'b0000);
        end
        checks++;
        if (tick3 !== 3'b111 || busy3 !== 3'b000) begin
            failures++;
            $display("FAIL reset_dut3 got tick=%b busy=%b exp tick=111 busy=000", tick3, busy3);
        end
        for (int k = 1; k <= 3; k++) begin
            step;
            checks++;
            if (tick !== 4'b1111 || busy !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle k=%0d got tick=%b busy=%b exp tick=1111 busy=0000", k, tick, busy);
            end
        end
    endtask

    task automatic test_periodic;
        logic [3:0] exp_tick;
        do_reset;
        load(2'd0, 8'd3, 1'b0);
        checks++;
        if (busy !== 4'b0001 || tick !== 4'b1111) begin
            failures++;
            $display("FAIL periodic_load got tick=%b busy=%b exp tick=1111 busy=0001", tick, busy);
        end
        for (int k = 1; k <= 12; k++) begin
            step;
            exp_tick = (k % 4 == 0) ? 4'b1110 : 4'b1111;
            checks++;
            if (tick !== exp_tick || busy !== 4'b0001) begin
                failures++;
                $display("FAIL periodic k=%0d got tick=%b busy=%b exp tick=%b busy=0001", k, tick, busy, exp_tick);
            end
        end
    endtask

    task automatic test_oneshot;
        logic [3:0] exp_tick;
        logic [3:0] exp_busy;
        do_reset;
        load(2'd2, 8'd5, 1'b1);
        checks++;
        if (busy !== 4'b0100) begin
            failures++;
            $display("FAIL oneshot_load_busy got=%b exp=%b", busy, 4'b0100);
        end
        for (int k = 1; k <= 12; k++) begin
            step;
            exp_tick = (k == 6) ? 4'b1011 : 4'b1111;
            exp_busy = (k < 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (tick !== exp_tick || busy !== exp_busy) begin
                failures++;
                $display("FAIL oneshot k=%0d got tick=%b busy=%b exp tick=%b busy=%b", k, tick, busy, exp_tick, exp_busy);
            end
        end
    endtask

    task automatic test_load_zero;
        do_reset;
        load(2'd1, 8'd0, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step;
            checks++;
            if (tick !== 4'b1111 || busy !== 4'b0000) begin
                failures++;
                $display("FAIL load_zero k=%0d got tick=%b busy=%b exp tick=1111 busy=0000", k, tick, busy);
            end
        end
    endtask

    task automatic test_load_clear_same_edge;
        logic [3:0] exp_tick;
        do_reset;
        load_n  = 1'b0;
        clear_n = 1'b0;
        sel     = 2'd1;
        data    = 8'd2;
        mode    = 1'b0;
        step;
        load_n  = 1'b1;
        clear_n = 1'b1;
        checks++;
        if (busy !== 4'b0010) begin
            failures++;
            $display("FAIL load_clear_busy got=%b exp=%b", busy, 4'b0010);
        end
        for (int k = 1; k <= 6; k++) begin
            step;
            exp_tick = (k == 3 || k == 6) ? 4'b1101 : 4'b1111;
            checks++;
            if (tick !== exp_tick) begin
                failures++;
                $display("FAIL load_clear k=%0d got tick=%b exp=%b", k, tick, exp_tick);
            end
        end
    endtask

    task automatic test_clear_running;
        logic [3:0] exp_tick;
        do_reset;
        load(2'd0, 8'd3, 1'b0);
        load(2'd3, 8'd1, 1'b0);
        step;
        clear_n = 1'b0;
        sel     = 2'd0;
        step;
        clear_n = 1'b1;
        checks++;
        if (busy !== 4'b1000 || tick !== 4'b0111) begin
            failures++;
            $display("FAIL clear_edge got tick=%b busy=%b exp tick=0111 busy=1000", tick, busy);
        end
        for (int k = 4; k <= 9; k++) begin
            step;
            exp_tick = (k % 2 == 1) ? 4'b0111 : 4'b1111;
            checks++;
            if (tick !== exp_tick || busy !== 4'b1000) begin
                failures++;
                $display("FAIL clear_running k=%0d got tick=%b busy=%b exp tick=%b busy=1000", k, tick, busy, exp_tick);
            end
        end
    endtask

    task automatic test_reset_midcount;
        do_reset;
        load(2'd0, 8'd3, 1'b0);
        step;
        step;
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step;
            checks++;
            if (tick !== 4'b1111 || busy !== 4'b0000) begin
                failures++;
                $display("FAIL reset_mid_hold k=%0d got tick=%b busy=%b exp tick=1111 busy=0000", k, tick, busy);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step;
            checks++;
            if (tick !== 4'b1111 || busy !== 4'b0000) begin
                failures++;
                $display("FAIL reset_mid_after k=%0d got tick=%b busy=%b exp tick=1111 busy=0000", k, tick, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_tick;
        do_reset;
        load(2'd3, 8'd3, 1'b0);
        load(2'd0, 8'd2, 1'b0);
        checks++;
        if (busy !== 4'b1001 || tick !== 4'b1111) begin
            failures++;
            $display("FAIL b2b_load got tick=%b busy=%b exp tick=1111 busy=1001", tick, busy);
        end
        for (int k = 2; k <= 8; k++) begin
            step;
            exp_tick = 4'b1111;
            if (k == 4 || k == 8) exp_tick[3] = 1'b0;
            if (k == 4 || k == 7) exp_tick[0] = 1'b0;
            checks++;
            if (tick !== exp_tick) begin
                failures++;
                $display("FAIL b2b k=%0d got tick=%b exp=%b", k, tick, exp_tick);
            end
        end
    endtask

    task automatic test_sel_out_of_range;
        logic [2:0] exp_tick3;
        do_reset;
        load(2'd0, 8'd3, 1'b0);
        load(2'd3, 8'd2, 1'b0);
        checks++;
        if (busy3 !== 3'b001) begin
            failures++;
            $display("FAIL oor_load busy got=%b exp=%b", busy3, 3'b001);
        end
        clear_n = 1'b0;
        sel     = 2'd3;
        step;
        clear_n = 1'b1;
        checks++;
        if (busy3 !== 3'b001) begin
            failures++;
            $display("FAIL oor_clear busy got=%b exp=%b", busy3, 3'b001);
        end
        for (int k = 3; k <= 8; k++) begin
            step;
            exp_tick3 = (k == 4 || k == 8) ? 3'b110 : 3'b111;
            checks++;
            if (tick3 !== exp_tick3 || busy3 !== 3'b001) begin
                failures++;
                $display("FAIL oor_run k=%0d got tick=%b busy=%b exp tick=%b busy=001", k, tick3, busy3, exp_tick3);
            end
        end
    endtask

    task automatic test_prescaler;
        logic [3:0] exp_tick;
        do_reset;
        load(2'd0, 8'd1, 1'b0);
        checks++;
        if (busy !== 4'b0001) begin
            failures++;
            $display("FAIL presc_busy got=%b exp=%b", busy, 4'b0001);
        end
        for (int k = 1; k <= 40; k++) begin
            step;
            exp_tick = (k % 8 == 7) ? 4'b1110 : 4'b1111;
            checks++;
            if (tick !== exp_tick) begin
                failures++;
                $display("FAIL presc k=%0d got tick=%b exp=%b", k, tick, exp_tick);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        load_n  = 1'b1;
        clear_n = 1'b1;
        sel     = 2'd0;
        data    = 8'd0;
        mode    = 1'b0;
        test_reset;
`ifdef SC_MTIMER_PRESCALER_EN
        test_prescaler;
`else
        test_periodic;
        test_oneshot;
        test_load_zero;
        test_load_clear_same_edge;
        test_clear_running;
        test_reset_midcount;
        test_back_to_back;
        test_sel_out_of_range;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
